// File: rtl/board_b_d_bus_pkg.sv
// board_b_d_bus_pkg: shared FSM encoding and B-D bus address decode constants
package board_b_d_bus_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} bus_state_t;
    localparam logic [1:0] SCROLL_IO_SEL = 2'b10;
    localparam int SCROLL_IO_SEL_LSB = 6;
    localparam int SCROLL_IDX_LSB = 1;
    localparam int CHARA_LAYER_BIT = 15;
endpackage

// File: rtl/board_b_d_bus_initiator.sv
// board_b_d_bus_initiator: valid/ready request to M72 B-D bus strobes with setup, strobe, hold and read timeout
module board_b_d_bus_initiator
    import board_b_d_bus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter logic [3:0] CHARA_BASE = 4'hD,
    parameter logic [15:0] OPEN_BUS = 16'hFFFF
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [19:0] REQ_ADDR,
    input  logic        REQ_WE,
    input  logic        REQ_IO,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_TIMEOUT,
    output logic [18:0] A,
    output logic [15:0] DIN,
    output logic [1:0]  BYTE_SEL,
    output logic        MRD,
    output logic        MWR,
    output logic        IORD,
    output logic        IOWR,
    output logic        CHARA,
    input  logic [15:0] DOUT,
    input  logic        DOUT_VALID
);
    localparam logic [8:0] S9 = 9'(STROBE_CYCLES);
    localparam logic [8:0] T9 = 9'(TIMEOUT_CYCLES);

    bus_state_t state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [8:0] cnt_inc;
    logic got, got_d, got_now, is_we, is_we_d, is_io, is_io_d, done;
    logic [18:0] a_d;
    logic [15:0] din_d, rsp_rdata_d;
    logic [1:0] byte_sel_d;
    logic rsp_timeout_d, chara_d, mrd_d, mwr_d, iord_d, iowr_d;
    logic unused_addr0;

    assign unused_addr0 = REQ_ADDR[0];
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign got_now = got | DOUT_VALID;
    // reads leave early once data arrived and the minimum width is met; the timeout only fires without data
    assign done = is_we ? cnt_inc >= S9 : (cnt_inc >= S9 && got_now) || cnt_inc == T9;

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        got_d = got;
        is_we_d = is_we;
        is_io_d = is_io;
        a_d = A;
        din_d = DIN;
        byte_sel_d = BYTE_SEL;
        chara_d = CHARA;
        mrd_d = MRD;
        mwr_d = MWR;
        iord_d = IORD;
        iowr_d = IOWR;
        rsp_rdata_d = RSP_RDATA;
        rsp_timeout_d = RSP_TIMEOUT;
        case (state)
            IDLE: if (CE && REQ_VALID && REQ_READY) begin
                a_d = REQ_ADDR[19:1];
                byte_sel_d = REQ_BE;
                din_d = REQ_WE ? REQ_WDATA : DIN;
                is_we_d = REQ_WE;
                is_io_d = REQ_IO;
                got_d = 1'b0;
                rsp_timeout_d = 1'b0;
                rsp_rdata_d = REQ_BE == 2'b00 ? OPEN_BUS : 16'h0000;
                chara_d = ~REQ_IO && REQ_ADDR[19:16] == CHARA_BASE && REQ_BE != 2'b00;
                state_d = REQ_BE == 2'b00 ? RESP : SETUP;
            end
            SETUP: if (CE) begin
                mrd_d = ~is_we & ~is_io;
                mwr_d = is_we & ~is_io;
                iord_d = ~is_we & is_io;
                iowr_d = is_we & is_io;
                cnt_d = 8'd0;
                state_d = STROBE;
            end
            STROBE: if (CE) begin
                cnt_d = cnt == 8'hFF ? cnt : cnt_inc[7:0];
                rsp_rdata_d = !is_we && DOUT_VALID ? DOUT : RSP_RDATA;
                got_d = got | (!is_we && DOUT_VALID);
                if (done) begin
                    {mrd_d, mwr_d, iord_d, iowr_d} = 4'b0000;
                    rsp_rdata_d = !is_we && !got_now ? OPEN_BUS : rsp_rdata_d;
                    rsp_timeout_d = !is_we && !got_now;
                    state_d = HOLD;
                end
            end
            HOLD: if (CE) begin
                chara_d = 1'b0;
                state_d = RESP;
            end
            RESP: state_d = RSP_READY ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt <= '0;
            got <= 1'b0;
            is_we <= 1'b0;
            is_io <= 1'b0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_TIMEOUT <= 1'b0;
            A <= '0;
            DIN <= '0;
            BYTE_SEL <= '0;
            CHARA <= 1'b0;
            {MRD, MWR, IORD, IOWR} <= 4'b0000;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            got <= got_d;
            is_we <= is_we_d;
            is_io <= is_io_d;
            REQ_READY <= state_d == IDLE;
            RSP_VALID <= state_d == RESP;
            RSP_RDATA <= rsp_rdata_d;
            RSP_TIMEOUT <= rsp_timeout_d;
            A <= a_d;
            DIN <= din_d;
            BYTE_SEL <= byte_sel_d;
            CHARA <= chara_d;
            {MRD, MWR, IORD, IOWR} <= {mrd_d, mwr_d, iord_d, iowr_d};
        end
    end
endmodule

// File: tb/tb_board_b_d_bus_initiator.sv
// tb_board_b_d_bus_initiator: table-driven transactions with a response scoreboard for the B-D bus initiator
module tb_board_b_d_bus_initiator;
    import board_b_d_bus_pkg::*;

    logic CLK_32M = 1'b0, RESET_N = 1'b0, CE = 1'b1;
    logic REQ_VALID = 1'b0, REQ_READY, REQ_WE = 1'b0, REQ_IO = 1'b0;
    logic [19:0] REQ_ADDR = '0;
    logic [1:0] REQ_BE = '0, BYTE_SEL;
    logic [15:0] REQ_WDATA = '0, RSP_RDATA, DIN, DOUT = '0;
    logic RSP_VALID, RSP_READY = 1'b0, RSP_TIMEOUT, DOUT_VALID = 1'b0;
    logic [18:0] A;
    logic MRD, MWR, IORD, IOWR, CHARA;

    board_b_d_bus_initiator dut (
        .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE(CE),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_WE(REQ_WE), .REQ_IO(REQ_IO), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_TIMEOUT(RSP_TIMEOUT), .A(A), .DIN(DIN), .BYTE_SEL(BYTE_SEL),
        .MRD(MRD), .MWR(MWR), .IORD(IORD), .IOWR(IOWR), .CHARA(CHARA),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID)
    );

    always #5 CLK_32M = ~CLK_32M;

    bit ce_slow = 1'b0;
    int unsigned ce_cnt = 0;
    always @(negedge CLK_32M) begin
        ce_cnt++;
        CE = !ce_slow || (ce_cnt % 4 == 0);
    end

    typedef struct {
        logic [19:0] addr; logic we; logic io; logic [1:0] be; logic [15:0] wdata;
        int dv_cyc; logic [15:0] dout; bit slow; int stall;
        logic [3:0] exp_mask; int exp_width; logic exp_chara; logic [15:0] exp_rdata; logic exp_to; int exp_pre;
    } vec_t;
    typedef struct { logic [15:0] rdata; logic to; } rsp_t;

    rsp_t sb[$];
    vec_t vecs[9];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int cyc, width, pre, post;
        logic [3:0] seen, strb;
        logic chara_ok, a_ok, bs_ok, din_ok, one_ok, ready_ok, stable_ok;
        rsp_t e;
        string p;
        p = $sformatf("v%0d", id);
        sb.push_back('{v.exp_rdata, v.exp_to});
        ce_slow = v.slow;
        @(negedge CLK_32M);
        REQ_VALID = 1'b1; REQ_ADDR = v.addr; REQ_WE = v.we; REQ_IO = v.io; REQ_BE = v.be; REQ_WDATA = v.wdata;
        cyc = 0;
        do begin @(negedge CLK_32M); cyc++; end while (REQ_READY && cyc < 100);
        REQ_VALID = 1'b0;
        width = 0; pre = 0; post = 0; seen = '0;
        {chara_ok, a_ok, bs_ok, din_ok, one_ok, ready_ok} = 6'b111111;
        while (!RSP_VALID && cyc < 300) begin
            strb = {MRD, MWR, IORD, IOWR};
            if (strb != 4'b0000) begin
                width++;
                seen |= strb;
                chara_ok &= CHARA === v.exp_chara;
                a_ok &= A === v.addr[19:1];
                bs_ok &= BYTE_SEL === v.be;
                if (v.we) din_ok &= DIN === v.wdata;
                if ($countones(strb) != 1) one_ok = 1'b0;
            end else if (width == 0) pre++;
            else post++;
            ready_ok &= !REQ_READY;
            DOUT_VALID = (MRD | IORD) && v.dv_cyc != 0 && width >= v.dv_cyc;
            DOUT = DOUT_VALID ? v.dout : 16'h0000;
            @(negedge CLK_32M);
            cyc++;
        end
        DOUT_VALID = 1'b0;
        DOUT = 16'h0000;
        chk({p, "_rsp_arrived"}, 32'(RSP_VALID), 32'd1);
        chk({p, "_strobe_mask"}, 32'(seen), 32'(v.exp_mask));
        chk({p, "_strobe_width"}, width, v.exp_width);
        chk({p, "_chara_addr_be_din"}, {chara_ok, a_ok, bs_ok, din_ok}, 32'hF);
        chk({p, "_single_strobe_no_ready"}, {one_ok, ready_ok}, 32'h3);
        if (v.exp_pre >= 0) chk({p, "_setup_hold"}, {pre, post}, {v.exp_pre, (width > 0 ? 1 : 0)});
        if (sb.size() == 0) chk({p, "_scoreboard_empty"}, 0, 1);
        else begin
            e = sb.pop_front();
            chk({p, "_rdata"}, 32'(RSP_RDATA), 32'(e.rdata));
            chk({p, "_timeout"}, 32'(RSP_TIMEOUT), 32'(e.to));
            chk({p, "_resp_chara_ready"}, {CHARA, REQ_READY}, 32'h0);
            stable_ok = 1'b1;
            repeat (v.stall) begin
                @(negedge CLK_32M);
                stable_ok &= RSP_VALID && !REQ_READY && RSP_RDATA === e.rdata && RSP_TIMEOUT === e.to;
            end
            if (v.stall > 0) chk({p, "_stall_stable"}, 32'(stable_ok), 32'd1);
        end
        RSP_READY = 1'b1;
        @(negedge CLK_32M);
        RSP_READY = 1'b0;
        chk({p, "_back_to_idle"}, {RSP_VALID, REQ_READY}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [19:0] io_addr, layer_addr;
        int cyc;
        io_addr = (20'(SCROLL_IO_SEL) << SCROLL_IO_SEL_LSB) | (20'(3'd0) << SCROLL_IDX_LSB);
        layer_addr = 20'hD0002 | (20'd1 << CHARA_LAYER_BIT);
        vecs[0] = '{20'hD0010, 1'b1, 1'b0, 2'b11, 16'h1234, 0, 16'h0, 1'b0, 0, 4'b0100, 2, 1'b1, 16'h0000, 1'b0, 1};
        vecs[1] = '{layer_addr, 1'b0, 1'b0, 2'b11, 16'h0, 1, 16'hBEEF, 1'b0, 0, 4'b1000, 2, 1'b1, 16'hBEEF, 1'b0, 1};
        vecs[2] = '{io_addr, 1'b1, 1'b1, 2'b11, 16'h0040, 0, 16'h0, 1'b0, 0, 4'b0001, 2, 1'b0, 16'h0000, 1'b0, 1};
        vecs[3] = '{io_addr, 1'b0, 1'b1, 2'b11, 16'h0, 0, 16'h0, 1'b0, 0, 4'b0010, 8, 1'b0, 16'hFFFF, 1'b1, 1};
        vecs[4] = '{20'h12346, 1'b0, 1'b0, 2'b11, 16'h0, 5, 16'hA5A5, 1'b0, 0, 4'b1000, 5, 1'b0, 16'hA5A5, 1'b0, 1};
        vecs[5] = '{20'hD0000, 1'b0, 1'b0, 2'b11, 16'h0, 8, 16'h5A5A, 1'b0, 0, 4'b1000, 8, 1'b1, 16'h5A5A, 1'b0, 1};
        vecs[6] = '{20'hD0000, 1'b0, 1'b0, 2'b00, 16'h0, 0, 16'h0, 1'b0, 10, 4'b0000, 0, 1'b0, 16'hFFFF, 1'b0, 0};
        vecs[7] = '{20'h00100, 1'b1, 1'b0, 2'b11, 16'hCAFE, 0, 16'h0, 1'b1, 0, 4'b0100, 8, 1'b0, 16'h0000, 1'b0, -1};
        vecs[8] = '{20'hD0010, 1'b1, 1'b0, 2'b01, 16'h00AA, 0, 16'h0, 1'b0, 0, 4'b0100, 2, 1'b1, 16'h0000, 1'b0, 1};

        #3;
        chk("reset_outputs", {REQ_READY, RSP_VALID, RSP_TIMEOUT, MRD, MWR, IORD, IOWR, CHARA}, 32'h0);
        chk("reset_bus", {A, BYTE_SEL}, 32'h0);
        chk("reset_data", {DIN, RSP_RDATA}, 32'h0);
        @(negedge CLK_32M);
        RESET_N = 1'b1;
        @(negedge CLK_32M);
        chk("idle_ready", {REQ_READY, RSP_VALID}, 32'h2);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);
        ce_slow = 1'b0;

        @(negedge CLK_32M);
        REQ_VALID = 1'b1; REQ_ADDR = 20'hD0010; REQ_WE = 1'b1; REQ_IO = 1'b0; REQ_BE = 2'b11; REQ_WDATA = 16'h1234;
        cyc = 0;
        do begin @(negedge CLK_32M); cyc++; end while (REQ_READY && cyc < 100);
        REQ_VALID = 1'b0;
        while (!MWR && cyc < 120) begin @(negedge CLK_32M); cyc++; end
        chk("rst_mid_mwr_chara", {MWR, CHARA}, 32'h3);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mid_drop", {MWR, CHARA, REQ_READY, RSP_VALID}, 32'h0);
        chk("rst_mid_addr", 32'(A), 32'h0);
        @(negedge CLK_32M);
        RESET_N = 1'b1;
        @(negedge CLK_32M);
        chk("rst_recover_idle", {REQ_READY, RSP_VALID, MWR}, 32'h4);
        run_txn(vecs[0], 9);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
